// File: rtl/boot_loader_ctrl_pkg.sv
// Shared command codes and FSM state encoding for the boot loader.
// Host protocol is little-endian: CMD, CNT_LO, CNT_HI, then CNT 4-byte words.
package boot_loader_ctrl_pkg;

  localparam logic [7:0] CMD_LOAD_I = 8'hA5;
  localparam logic [7:0] CMD_LOAD_D = 8'h5A;
  localparam logic [7:0] CMD_RUN    = 8'hF0;
  localparam logic [7:0] CMD_HALT   = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_ERROR
  } state_t;

  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b == CMD_LOAD_I) || (b == CMD_LOAD_D);
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Host byte stream into the boot loader; a byte moves when s_valid && s_ready.
// master = byte source (UART RX / debug FIFO), slave = boot_loader_ctrl.
interface boot_loader_ctrl_if;

  logic [7:0] s_dat;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_dat,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_dat,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/boot_loader_ctrl_word_assembler.sv
// Packs accepted bytes LSB-first into a word; word_vld is combinational with the last byte.
// No storage beyond one word; caller gates byte_vld, clear drops any partial word.
module boot_loader_ctrl_word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  output logic                  word_vld,
  output logic [DATA_WIDTH-1:0] word_dat
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] shift_q;

  always_comb begin
    word_dat = shift_q;
    word_dat[{byte_idx, 3'b000} +: 8] = byte_dat;
    word_vld = byte_vld && (byte_idx == IDX_W'(LANES - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (byte_vld) begin
      shift_q  <= word_dat;
      byte_idx <= byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Loads instruction/data BRAM from a host byte stream, then releases the core; write strobe
// follows the 4th byte of a word by one cycle, s_ready drops only in WRITE, ERROR and reset.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  boot_loader_ctrl_if.slave     host,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  init_done,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  load_done,
  output logic                  err
);

  state_t                state;
  logic                  s_ready_q;
  logic                  tgt_d;
  logic [7:0]            cnt_lo_q;
  logic [15:0]           count_q;
  logic [15:0]           word_idx;
  logic [15:0]           cnt_next;
  logic [15:0]           word_idx_next;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  accept;
  logic                  asm_clear;
  logic                  asm_byte_vld;
  logic                  asm_word_vld;
  logic [DATA_WIDTH-1:0] asm_word_dat;

  assign host.s_ready  = s_ready_q;
  assign accept        = host.s_valid && s_ready_q;
  assign cnt_next      = {host.s_dat, cnt_lo_q};
  assign word_idx_next = word_idx + 16'd1;
  assign wr_addr       = {word_idx[ADDR_WIDTH-3:0], 2'b00};
  assign asm_byte_vld  = accept && (state == ST_DATA);
  // Outside a load the assembler is held empty so a fresh load never sees stale lanes.
  assign asm_clear     = (state != ST_DATA) && (state != ST_WRITE);

  boot_loader_ctrl_word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .byte_vld (asm_byte_vld),
    .byte_dat (host.s_dat),
    .word_vld (asm_word_vld),
    .word_dat (asm_word_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      s_ready_q <= 1'b0;
      tgt_d     <= 1'b0;
      cnt_lo_q  <= '0;
      count_q   <= '0;
      word_idx  <= '0;
      i_w_addr  <= '0;
      i_w_dat   <= '0;
      i_w_enb   <= 1'b0;
      d_w_addr  <= '0;
      d_w_dat   <= '0;
      d_w_enb   <= 1'b0;
      init_done <= 1'b0;
      pc_stall  <= 1'b1;
      i_r_enb   <= 1'b0;
      rd_enbl   <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      i_w_enb   <= 1'b0;
      d_w_enb   <= 1'b0;
      load_done <= 1'b0;
      s_ready_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_load_cmd(host.s_dat)) begin
              tgt_d <= (host.s_dat == CMD_LOAD_D);
              state <= ST_CNT_LO;
            end else if (host.s_dat == CMD_RUN) begin
              state     <= ST_RUN;
              pc_stall  <= 1'b0;
              init_done <= 1'b1;
              i_r_enb   <= 1'b1;
              rd_enbl   <= 1'b1;
            end else begin
              state     <= ST_ERROR;
              err       <= 1'b1;
              s_ready_q <= 1'b0;
            end
          end
        end

        ST_CNT_LO: begin
          if (accept) begin
            cnt_lo_q <= host.s_dat;
            state    <= ST_CNT_HI;
          end
        end

        ST_CNT_HI: begin
          if (accept) begin
            count_q <= cnt_next;
            if (cnt_next == 16'd0) begin
              state     <= ST_IDLE;
              load_done <= 1'b1;
            end else if (cnt_next > 16'(DEPTH_WORDS)) begin
              state     <= ST_ERROR;
              err       <= 1'b1;
              s_ready_q <= 1'b0;
            end else begin
              word_idx <= '0;
              state    <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (asm_word_vld) begin
            state     <= ST_WRITE;
            s_ready_q <= 1'b0;
            if (tgt_d) begin
              d_w_enb  <= 1'b1;
              d_w_addr <= wr_addr;
              d_w_dat  <= asm_word_dat;
            end else begin
              i_w_enb  <= 1'b1;
              i_w_addr <= wr_addr;
              i_w_dat  <= asm_word_dat;
            end
          end
        end

        ST_WRITE: begin
          word_idx <= word_idx_next;
          if (word_idx_next == count_q) begin
            state     <= ST_IDLE;
            load_done <= 1'b1;
          end else begin
            state <= ST_DATA;
          end
        end

        ST_RUN: begin
          // Anything but HALT is consumed and dropped while the core runs.
          if (accept && (host.s_dat == CMD_HALT)) begin
            state     <= ST_IDLE;
            pc_stall  <= 1'b1;
            init_done <= 1'b0;
            i_r_enb   <= 1'b0;
            rd_enbl   <= 1'b0;
          end
        end

        default: begin
          state     <= ST_ERROR;
          s_ready_q <= 1'b0;
          err       <= 1'b1;
          pc_stall  <= 1'b1;
          init_done <= 1'b0;
          i_r_enb   <= 1'b0;
          rd_enbl   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Randomized host-byte stimulus checked against a message-level model of expected BRAM writes.
module tb_boot_loader_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_w_addr, d_w_addr;
  logic [DW-1:0] i_w_dat, d_w_dat;
  logic          i_w_enb, d_w_enb, init_done, pc_stall, i_r_enb, rd_enbl, load_done, err;

  boot_loader_ctrl_if host();

  boot_loader_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .i_w_addr  (i_w_addr),
    .i_w_dat   (i_w_dat),
    .i_w_enb   (i_w_enb),
    .d_w_addr  (d_w_addr),
    .d_w_dat   (d_w_dat),
    .d_w_enb   (d_w_enb),
    .init_done (init_done),
    .pc_stall  (pc_stall),
    .i_r_enb   (i_r_enb),
    .rd_enbl   (rd_enbl),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [31:0] wbuf [0:DEPTH-1];
  int          n_vec = 0;
  int          n_bad = 0;
  int          ld_seen = 0;
  int          exp_ld = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the next write the model predicted.
  always @(negedge clk) begin
    if (rst) begin
      if (i_w_enb || d_w_enb) begin
        chk("strobe_excl", 32'(i_w_enb && d_w_enb), 32'd0);
        chk("rdy_in_write", 32'(host.s_ready), 32'd0);
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          chk("wr_target", 32'(d_w_enb), 32'(mon_w.is_d));
          chk("wr_addr", 32'(d_w_enb ? d_w_addr : i_w_addr), 32'(mon_w.addr));
          chk("wr_dat", d_w_enb ? d_w_dat : i_w_dat, mon_w.dat);
        end
      end
      if (load_done) ld_seen++;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the byte was taken.
  task automatic send(input logic [7:0] b, input int bubbles);
    int   guard;
    logic r;
    repeat (bubbles) begin @(posedge clk); #1; end
    host.s_dat   = b;
    host.s_valid = 1'b1;
    guard = 0;
    r = 1'b0;
    while (!r && guard < 64) begin
      @(negedge clk);
      r = host.s_ready;
      @(posedge clk);
      guard++;
    end
    chk("accept", 32'(r), 32'd1);
    #1;
    host.s_valid = 1'b0;
    host.s_dat   = 8'($urandom);
  endtask

  task automatic load(input logic is_d, input int cnt, input logic bp);
    logic [15:0] c;
    c = 16'(cnt);
    send(is_d ? 8'h5A : 8'hA5, bp ? 1 : $urandom_range(0, 2));
    send(c[7:0], bp ? 1 : $urandom_range(0, 2));
    send(c[15:8], bp ? 1 : $urandom_range(0, 2));
    exp_ld++;
    if (cnt == 0) begin
      @(negedge clk);
      chk("ld_done_zero", 32'(load_done), 32'd1);
      @(posedge clk); #1;
    end
    for (int k = 0; k < cnt; k++) begin
      exp_q.push_back('{is_d, AW'(k * 4), wbuf[k]});
      for (int b = 0; b < 4; b++) send(wbuf[k][8*b +: 8], bp ? 1 : $urandom_range(0, 2));
      @(negedge clk);
      chk("wr_latency", 32'(is_d ? d_w_enb : i_w_enb), 32'd1);
      if (k == cnt - 1) begin
        @(negedge clk);
        chk("ld_done", 32'(load_done), 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("wr_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset;
    host.s_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {23'd0, host.s_ready, i_w_enb, d_w_enb, init_done, i_r_enb, rd_enbl,
                    load_done, err, pc_stall}, 32'd1);
    chk("rst_addr", 32'(i_w_addr | d_w_addr), 32'd0);
    chk("rst_dat", i_w_dat | d_w_dat, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic expect_error(input string tag);
    @(negedge clk);
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_rdy"}, 32'(host.s_ready), 32'd0);
    chk({tag, "_stall"}, {30'd0, pc_stall, init_done}, 32'd2);
    host.s_dat   = 8'hA5;
    host.s_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk({tag, "_held"}, {30'd0, err, host.s_ready}, 32'd2);
    end
    host.s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_and_halt;
    logic [7:0] b;
    send(8'hF0, $urandom_range(0, 2));
    @(negedge clk);
    chk("run_ctl", {28'd0, pc_stall, init_done, i_r_enb, rd_enbl}, 32'h7);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      if (b == 8'h0F) b = 8'h10;
      send(b, $urandom_range(0, 2));
    end
    @(negedge clk);
    chk("run_ignore", {28'd0, pc_stall, init_done, i_r_enb, rd_enbl}, 32'h7);
    @(posedge clk); #1;
    send(8'h0F, 0);
    @(negedge clk);
    chk("halt_ctl", {28'd0, pc_stall, init_done, i_r_enb, rd_enbl}, 32'h8);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    host.s_valid = 1'b0;
    host.s_dat   = 8'h00;
    do_reset();

    // Directed instruction load
    wbuf[0] = 32'h00500593; wbuf[1] = 32'h00A58593; wbuf[2] = 32'h00B50533;
    load(1'b0, 3, 1'b0);

    // Directed data load, then run/halt
    wbuf[0] = 32'h00000010; wbuf[1] = 32'h00000020;
    load(1'b1, 2, 1'b0);
    run_and_halt();

    // Zero count and backpressure on every byte
    load(1'b0, 0, 1'b0);
    wbuf[0] = 32'hCAFEF00D;
    load(1'b1, 1, 1'b1);

    // Randomized loads
    for (int t = 0; t < 8; t++) begin
      int cnt;
      cnt = $urandom_range(0, 6);
      for (int k = 0; k < cnt; k++) wbuf[k] = $urandom;
      load(1'($urandom_range(0, 1)), cnt, 1'($urandom_range(0, 1)));
    end

    // Largest legal load reaches the top word address
    for (int k = 0; k < DEPTH; k++) wbuf[k] = $urandom;
    load(1'b0, DEPTH, 1'b0);
    run_and_halt();

    // Oversized count
    send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0);
    expect_error("cnt257");
    do_reset();

    // Unknown command
    send(8'h33, 0);
    expect_error("badcmd");
    do_reset();

    // Reset after two data bytes, then a clean single-word load
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'hEE, 0); send(8'hDD, 0);
    do_reset();
    wbuf[0] = 32'h12345678;
    load(1'b0, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("ld_count", 32'(ld_seen), 32'(exp_ld));
    chk("wr_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
